// File: rtl/vga_console_pkg.sv
// Shared types and constants for the VGA text-console controller.
package vga_console_pkg;

  localparam int unsigned COLS_DEF = 80;
  localparam int unsigned ROWS_DEF = 60;
  localparam int unsigned AW_DEF   = 13;
  localparam int unsigned CHW      = 7;
  localparam int unsigned RW       = 6;
  localparam int unsigned CW       = 7;

  localparam logic [CHW-1:0] ASC_BS    = 7'h08;
  localparam logic [CHW-1:0] ASC_TAB   = 7'h09;
  localparam logic [CHW-1:0] ASC_LF    = 7'h0A;
  localparam logic [CHW-1:0] ASC_FF    = 7'h0C;
  localparam logic [CHW-1:0] ASC_CR    = 7'h0D;
  localparam logic [CHW-1:0] ASC_SPACE = 7'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUT,
    ST_SCROLL_RD,
    ST_SCROLL_WR,
    ST_SCROLL_BLANK,
    ST_CLEAR
  } state_e;

  function automatic logic is_printable(input logic [CHW-1:0] c);
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

endpackage

// File: rtl/vga_console_cursor.sv
// Cursor position registers with newline/wrap handling; emits the linear
// RAM address and a flag when the requested move would leave the last row.
module vga_console_cursor
  import vga_console_pkg::*;
#(
  parameter int unsigned COLS = COLS_DEF,
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned AW   = AW_DEF
) (
  input  logic          sys_clk,
  input  logic          clrn,
  input  logic          i_adv,
  input  logic          i_nl,
  input  logic          i_cr,
  input  logic          i_bs,
  input  logic          i_tab,
  input  logic          i_home,
  input  logic          i_last,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic [AW-1:0] o_addr,
  output logic          o_scroll_c
);

  localparam int unsigned   TW       = CW + 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [TW-1:0] w_tab_col;
  logic          w_tab_wrap;
  logic          w_adv_wrap;
  logic          w_newline;

  // Next tab stop is one bit wider so a stop past the last column is visible.
  assign w_tab_col  = {1'b0, r_col & ~CW'(7)} + TW'(8);
  assign w_tab_wrap = i_tab && (w_tab_col >= TW'(COLS));
  assign w_adv_wrap = i_adv && (r_col == COL_LAST);
  assign w_newline  = i_nl || w_tab_wrap || w_adv_wrap;

  assign o_scroll_c = w_newline && (r_row == ROW_LAST);
  assign o_addr     = AW'(r_row) * AW'(COLS) + AW'(r_col);
  assign o_row      = r_row;
  assign o_col      = r_col;

  // Row saturates on the last line; the scroll sequence moves the text instead.
  always_ff @(posedge sys_clk or negedge clrn) begin
    if (!clrn) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_home) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_last) begin
      r_row <= ROW_LAST;
      r_col <= '0;
    end else if (w_newline) begin
      r_col <= '0;
      if (r_row != ROW_LAST) r_row <= r_row + RW'(1);
    end else if (i_cr) begin
      r_col <= '0;
    end else if (i_bs && (r_col != '0)) begin
      r_col <= r_col - CW'(1);
    end else if (i_tab) begin
      r_col <= w_tab_col[CW-1:0];
    end else if (i_adv) begin
      r_col <= r_col + CW'(1);
    end
  end

endmodule

// File: rtl/vga_console_ctrl.sv
// Text-console controller: character writes, control codes, scroll and clear
// over the character-RAM port. Define VGA_CONSOLE_TAB_EN to enable 0x09 tab stops.
module vga_console_ctrl
  import vga_console_pkg::*;
#(
  parameter int unsigned COLS = COLS_DEF,
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned AW   = AW_DEF
) (
  input  logic           sys_clk,
  input  logic           clrn,
  input  logic           ch_valid,
  input  logic [CHW-1:0] ch_data,
  output logic           ch_ready,
  input  logic           clr_req,
  output logic           cram_sel,
  output logic           cram_we,
  output logic [AW-1:0]  cram_a,
  output logic [CHW-1:0] cram_d,
  input  logic [CHW-1:0] cram_q,
  output logic           busy,
  output logic [RW-1:0]  cur_row,
  output logic [CW-1:0]  cur_col
);

  localparam logic [AW-1:0] A_LAST    = AW'(COLS * ROWS - 1);
  localparam logic [AW-1:0] A_SCR_END = AW'((ROWS - 1) * COLS - 1);
  localparam logic [AW-1:0] A_BLANK0  = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] A_COLS    = AW'(COLS);

  state_e         r_state;
  logic [AW-1:0]  r_idx;
  logic           r_put_adv;
  logic           r_cram_sel;
  logic           r_cram_we;
  logic [AW-1:0]  r_cram_a;
  logic [CHW-1:0] r_cram_d;
  logic           r_busy;

  logic           w_ready;
  logic           w_accept;
  logic           w_adv, w_nl, w_cr, w_bs, w_tab, w_home, w_last;
  logic [AW-1:0]  w_addr;
  logic           w_scroll;
  logic [CW-1:0]  w_col;

  assign w_ready  = (r_state == ST_IDLE) && !clr_req && clrn;
  assign w_accept = ch_valid && w_ready;

  // Cursor commands decoded from the accepted code and sequence completion.
  always_comb begin
    w_nl   = 1'b0;
    w_cr   = 1'b0;
    w_bs   = 1'b0;
    w_tab  = 1'b0;
    if (w_accept) begin
      w_nl = (ch_data == ASC_LF);
      w_cr = (ch_data == ASC_CR);
      w_bs = (ch_data == ASC_BS) && (w_col != '0);
`ifdef VGA_CONSOLE_TAB_EN
      w_tab = (ch_data == ASC_TAB);
`else
      w_tab = 1'b0;
`endif
    end
    w_adv  = (r_state == ST_PUT) && r_put_adv;
    w_home = (r_state == ST_CLEAR) && (r_idx == A_LAST);
    w_last = (r_state == ST_SCROLL_BLANK) && (r_idx == A_LAST);
  end

  vga_console_cursor #(
    .COLS (COLS),
    .ROWS (ROWS),
    .AW   (AW)
  ) u_cursor (
    .sys_clk    (sys_clk),
    .clrn       (clrn),
    .i_adv      (w_adv),
    .i_nl       (w_nl),
    .i_cr       (w_cr),
    .i_bs       (w_bs),
    .i_tab      (w_tab),
    .i_home     (w_home),
    .i_last     (w_last),
    .o_row      (cur_row),
    .o_col      (w_col),
    .o_addr     (w_addr),
    .o_scroll_c (w_scroll)
  );

  // Port outputs are registered one step ahead: each branch loads what the
  // RAM port must show during the state being entered. r_cram_d doubles as
  // the scroll holding register.
  always_ff @(posedge sys_clk or negedge clrn) begin
    if (!clrn) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_put_adv  <= 1'b0;
      r_cram_sel <= 1'b0;
      r_cram_we  <= 1'b0;
      r_cram_a   <= '0;
      r_cram_d   <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_cram_sel <= 1'b0;
      r_cram_we  <= 1'b0;
      r_busy     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (clr_req || (w_accept && (ch_data == ASC_FF))) begin
            r_state    <= ST_CLEAR;
            r_idx      <= '0;
            r_cram_sel <= 1'b1;
            r_cram_we  <= 1'b1;
            r_cram_a   <= '0;
            r_cram_d   <= ASC_SPACE;
            r_busy     <= 1'b1;
          end else if (w_accept && is_printable(ch_data)) begin
            r_state    <= ST_PUT;
            r_put_adv  <= 1'b1;
            r_cram_sel <= 1'b1;
            r_cram_we  <= 1'b1;
            r_cram_a   <= w_addr;
            r_cram_d   <= ch_data;
            r_busy     <= 1'b1;
          end else if (w_bs) begin
            r_state    <= ST_PUT;
            r_put_adv  <= 1'b0;
            r_cram_sel <= 1'b1;
            r_cram_we  <= 1'b1;
            r_cram_a   <= w_addr - AW'(1);
            r_cram_d   <= ASC_SPACE;
            r_busy     <= 1'b1;
          end else if (w_scroll) begin
            r_state    <= ST_SCROLL_RD;
            r_idx      <= '0;
            r_cram_sel <= 1'b1;
            r_cram_a   <= A_COLS;
            r_busy     <= 1'b1;
          end
        end
        ST_PUT: begin
          if (w_scroll) begin
            r_state    <= ST_SCROLL_RD;
            r_idx      <= '0;
            r_cram_sel <= 1'b1;
            r_cram_a   <= A_COLS;
            r_busy     <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SCROLL_RD: begin
          r_state    <= ST_SCROLL_WR;
          r_cram_sel <= 1'b1;
          r_cram_we  <= 1'b1;
          r_cram_a   <= r_idx;
          r_cram_d   <= cram_q;
          r_busy     <= 1'b1;
        end
        ST_SCROLL_WR: begin
          r_cram_sel <= 1'b1;
          r_busy     <= 1'b1;
          if (r_idx == A_SCR_END) begin
            r_state   <= ST_SCROLL_BLANK;
            r_idx     <= A_BLANK0;
            r_cram_we <= 1'b1;
            r_cram_a  <= A_BLANK0;
            r_cram_d  <= ASC_SPACE;
          end else begin
            r_state  <= ST_SCROLL_RD;
            r_idx    <= r_idx + AW'(1);
            r_cram_a <= r_idx + AW'(1) + A_COLS;
          end
        end
        ST_SCROLL_BLANK, ST_CLEAR: begin
          if (r_idx == A_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_idx      <= r_idx + AW'(1);
            r_cram_sel <= 1'b1;
            r_cram_we  <= 1'b1;
            r_cram_a   <= r_idx + AW'(1);
            r_cram_d   <= ASC_SPACE;
            r_busy     <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ch_ready = w_ready;
  assign cram_sel = r_cram_sel;
  assign cram_we  = r_cram_we;
  assign cram_a   = r_cram_a;
  assign cram_d   = r_cram_d;
  assign busy     = r_busy;
  assign cur_col  = w_col;

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Bench for vga_console_ctrl: RAM model on the port, screen/cursor reference model.
`timescale 1ns/1ps
module tb_vga_console_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int AW    = 13;
  localparam int TOTAL = COLS * ROWS;

  logic          sys_clk = 1'b0;
  logic          clrn = 1'b0;
  logic          ch_valid = 1'b0;
  logic [6:0]    ch_data = '0;
  logic          clr_req = 1'b0;
  logic          ch_ready, cram_sel, cram_we, busy;
  logic [AW-1:0] cram_a;
  logic [6:0]    cram_d, cram_q;
  logic [5:0]    cur_row;
  logic [6:0]    cur_col;

  int n_checks = 0;
  int n_errors = 0;

  vga_console_ctrl dut (
    .sys_clk (sys_clk), .clrn (clrn), .ch_valid (ch_valid), .ch_data (ch_data),
    .ch_ready (ch_ready), .clr_req (clr_req), .cram_sel (cram_sel), .cram_we (cram_we),
    .cram_a (cram_a), .cram_d (cram_d), .cram_q (cram_q), .busy (busy),
    .cur_row (cur_row), .cur_col (cur_col)
  );

  always #10 sys_clk = ~sys_clk;

  // Character RAM behind the port, plus write statistics.
  logic [6:0]    ram [0:8191];
  logic [6:0]    exp_ram [0:TOTAL-1];
  logic          fill_req = 1'b0;
  int            wr_cnt = 0;
  int            sp_cnt = 0;
  logic [AW-1:0] last_a = '0;
  logic [6:0]    last_d = '0;

  assign cram_q = ram[cram_a];

  always @(posedge sys_clk) begin
    if (cram_sel && cram_we) begin
      ram[cram_a] = cram_d;
      wr_cnt++;
      if (cram_d == 7'h20) sp_cnt++;
      last_a = cram_a;
      last_d = cram_d;
    end else if (fill_req) begin
      for (int i = 0; i < TOTAL; i++) ram[i] = exp_ram[i];
    end
  end

  // Reference model: screen contents and cursor as the console should show them.
  int m_row = 0;
  int m_col = 0;

  function automatic void m_clear();
    for (int i = 0; i < TOTAL; i++) exp_ram[i] = 7'h20;
    m_row = 0;
    m_col = 0;
  endfunction

  function automatic void m_newline();
    m_col = 0;
    if (m_row == ROWS - 1) begin
      for (int i = 0; i < TOTAL - COLS; i++) exp_ram[i] = exp_ram[i + COLS];
      for (int i = TOTAL - COLS; i < TOTAL; i++) exp_ram[i] = 7'h20;
    end else begin
      m_row++;
    end
  endfunction

  function automatic void m_char(input logic [6:0] c);
    if (c >= 7'h20 && c <= 7'h7E) begin
      exp_ram[m_row * COLS + m_col] = c;
      if (m_col == COLS - 1) m_newline();
      else m_col++;
    end else if (c == 7'h0A) begin
      m_newline();
    end else if (c == 7'h0D) begin
      m_col = 0;
    end else if (c == 7'h08) begin
      if (m_col > 0) begin
        m_col--;
        exp_ram[m_row * COLS + m_col] = 7'h20;
      end
    end else if (c == 7'h0C) begin
      m_clear();
`ifdef VGA_CONSOLE_TAB_EN
    end else if (c == 7'h09) begin
      m_col = (m_col / 8 + 1) * 8;
      if (m_col >= COLS) m_newline();
`endif
    end
  endfunction

  function automatic int ram_diffs();
    int d = 0;
    for (int i = 0; i < TOTAL; i++) if (ram[i] !== exp_ram[i]) d++;
    return d;
  endfunction

  function automatic logic [6:0] rand_char();
    int r;
    logic [6:0] others [5];
    others = '{7'h00, 7'h07, 7'h1B, 7'h7F, 7'h01};
    r = $urandom_range(0, 99);
    if (r < 70) return 7'($urandom_range(32, 126));
    if (r < 80) return 7'h0A;
    if (r < 85) return 7'h0D;
    if (r < 92) return 7'h08;
    if (r < 96) return 7'h09;
    return others[$urandom_range(0, 4)];
  endfunction

  // Offer one character; returns #1 after the accepting edge.
  task automatic send_char(input logic [6:0] c);
    int n = 0;
    @(negedge sys_clk);
    ch_valid = 1'b1;
    ch_data  = c;
    while (!ch_ready && n < 20000) begin
      @(negedge sys_clk);
      n++;
    end
    if (!ch_ready) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: ch_ready=%b after %0d cycles, required 1", ch_ready, n);
      ch_valid = 1'b0;
      return;
    end
    @(posedge sys_clk);
    #1;
    ch_valid = 1'b0;
    m_char(c);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 30000) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    if (busy) begin
      n_checks++; n_errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    #3;
    ch_valid = 1'b1;
    ch_data  = 7'h41;
    #1;
    n_checks++;
    if ({cram_sel, cram_we, busy, ch_ready} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_ctl: sel/we/busy/ready=%b required 0000", {cram_sel, cram_we, busy, ch_ready});
    end
    n_checks++;
    if (cram_a !== '0 || cram_d !== '0) begin
      n_errors++;
      $display("FAIL reset_port: a=%0d d=%h required 0/00", cram_a, cram_d);
    end
    n_checks++;
    if (cur_row !== 6'd0 || cur_col !== 7'd0) begin
      n_errors++;
      $display("FAIL reset_cursor: (%0d,%0d) required (0,0)", cur_row, cur_col);
    end
    ch_valid = 1'b0;
    repeat (2) @(negedge sys_clk);
    clrn = 1'b1;
    for (int i = 0; i < TOTAL; i++) exp_ram[i] = 7'($urandom_range(32, 126));
    m_row = 0;
    m_col = 0;
    @(negedge sys_clk);
    fill_req = 1'b1;
    @(negedge sys_clk);
    fill_req = 1'b0;
  endtask

  task automatic test_put_char();
    int n;
    send_char(7'h41);
    n_checks++;
    if (cram_sel !== 1'b1 || cram_we !== 1'b1 || cram_a !== 13'd0 || cram_d !== 7'h41) begin
      n_errors++;
      $display("FAIL put_write: sel=%b we=%b a=%0d d=%h required 1 1 0 41", cram_sel, cram_we, cram_a, cram_d);
    end
    wait_idle(n);
    n_checks++;
    if (n != 1) begin
      n_errors++;
      $display("FAIL put_busy: busy cycles=%0d required 1", n);
    end
    n_checks++;
    if (cur_row !== 6'd0 || cur_col !== 7'd1) begin
      n_errors++;
      $display("FAIL put_cursor: (%0d,%0d) required (0,1)", cur_row, cur_col);
    end
  endtask

  task automatic test_row_fill();
    int n, nmax, w0;
    send_char(7'h0D);
    w0 = wr_cnt;
    nmax = 0;
    for (int i = 0; i < COLS; i++) begin
      send_char(7'($urandom_range(32, 126)));
      wait_idle(n);
      if (n > nmax) nmax = n;
    end
    n_checks++;
    if (last_a !== 13'd79 || wr_cnt - w0 != COLS) begin
      n_errors++;
      $display("FAIL row_fill_writes: last_a=%0d writes=%0d required 79/80", last_a, wr_cnt - w0);
    end
    n_checks++;
    if (nmax != 1 || cur_row !== 6'd1 || cur_col !== 7'd0) begin
      n_errors++;
      $display("FAIL row_fill_cursor: (%0d,%0d) max busy=%0d required (1,0) 1", cur_row, cur_col, nmax);
    end
    n_checks++;
    if (ram_diffs() != 0) begin
      n_errors++;
      $display("FAIL row_fill_ram: %0d cells differ, required 0", ram_diffs());
    end
  endtask

  task automatic test_scroll();
    int n, blanks;
    while (m_row < ROWS - 1) begin
      send_char(7'h0A);
      wait_idle(n);
    end
    send_char(7'h0D);
    for (int i = 0; i < 5; i++) begin
      send_char(7'($urandom_range(32, 126)));
      wait_idle(n);
    end
    n_checks++;
    if (cur_row !== 6'd59 || cur_col !== 7'd5) begin
      n_errors++;
      $display("FAIL scroll_setup: (%0d,%0d) required (59,5)", cur_row, cur_col);
    end
    send_char(7'h0A);
    wait_idle(n);
    n_checks++;
    if (n != 9520) begin
      n_errors++;
      $display("FAIL scroll_busy: busy cycles=%0d required 9520", n);
    end
    blanks = 0;
    for (int i = TOTAL - COLS; i < TOTAL; i++) if (ram[i] === 7'h20) blanks++;
    n_checks++;
    if (blanks != COLS) begin
      n_errors++;
      $display("FAIL scroll_blank_row: spaces=%0d required 80", blanks);
    end
    n_checks++;
    if (ram_diffs() != 0) begin
      n_errors++;
      $display("FAIL scroll_ram: %0d cells differ, required 0", ram_diffs());
    end
    n_checks++;
    if (cur_row !== 6'd59 || cur_col !== 7'd0) begin
      n_errors++;
      $display("FAIL scroll_cursor: (%0d,%0d) required (59,0)", cur_row, cur_col);
    end
  endtask

  task automatic test_clear();
    int n, w0, s0;
    @(negedge sys_clk);
    clr_req  = 1'b1;
    ch_valid = 1'b1;
    ch_data  = 7'h5A;
    #1;
    n_checks++;
    if (ch_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_ready: ch_ready=%b required 0", ch_ready);
    end
    w0 = wr_cnt;
    s0 = sp_cnt;
    @(posedge sys_clk);
    #1;
    clr_req  = 1'b0;
    ch_valid = 1'b0;
    m_clear();
    wait_idle(n);
    n_checks++;
    if (n != 4800 || wr_cnt - w0 != 4800 || sp_cnt - s0 != 4800) begin
      n_errors++;
      $display("FAIL clear_count: busy=%0d writes=%0d spaces=%0d required 4800 each", n, wr_cnt - w0, sp_cnt - s0);
    end
    n_checks++;
    if (cur_row !== 6'd0 || cur_col !== 7'd0 || ram_diffs() != 0) begin
      n_errors++;
      $display("FAIL clear_result: (%0d,%0d) diffs=%0d required (0,0) 0", cur_row, cur_col, ram_diffs());
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    send_char(7'h0C);
    repeat (100) @(posedge sys_clk);
    #3;
    clrn = 1'b0;
    #1;
    n_checks++;
    if (cram_sel !== 1'b0 || cram_we !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_async: sel=%b we=%b busy=%b required 0 0 0", cram_sel, cram_we, busy);
    end
    repeat (2) @(negedge sys_clk);
    clrn = 1'b1;
    @(posedge sys_clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || cram_sel !== 1'b0 || ch_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_idle: busy=%b sel=%b ready=%b required 0 0 1", busy, cram_sel, ch_ready);
    end
    send_char(7'h0C);
    wait_idle(n);
    n_checks++;
    if (n != 4800 || ram_diffs() != 0) begin
      n_errors++;
      $display("FAIL reclear: busy=%0d diffs=%0d required 4800 0", n, ram_diffs());
    end
  endtask

  task automatic test_backspace();
    int n, w0;
    for (int i = 0; i < 3; i++) begin
      send_char(7'h0A);
      wait_idle(n);
    end
    w0 = wr_cnt;
    send_char(7'h08);
    wait_idle(n);
    repeat (3) @(posedge sys_clk);
    #1;
    n_checks++;
    if (wr_cnt != w0 || n != 0 || cur_row !== 6'd3 || cur_col !== 7'd0) begin
      n_errors++;
      $display("FAIL bs_col0: writes=%0d busy=%0d (%0d,%0d) required 0 0 (3,0)", wr_cnt - w0, n, cur_row, cur_col);
    end
    for (int i = 0; i < 4; i++) begin
      send_char(7'h61 + 7'(i));
      wait_idle(n);
    end
    send_char(7'h08);
    n_checks++;
    if (cram_we !== 1'b1 || cram_a !== 13'd243 || cram_d !== 7'h20) begin
      n_errors++;
      $display("FAIL bs_write: we=%b a=%0d d=%h required 1 243 20", cram_we, cram_a, cram_d);
    end
    wait_idle(n);
    n_checks++;
    if (cur_row !== 6'd3 || cur_col !== 7'd3 || ram_diffs() != 0) begin
      n_errors++;
      $display("FAIL bs_result: (%0d,%0d) diffs=%0d required (3,3) 0", cur_row, cur_col, ram_diffs());
    end
  endtask

  task automatic test_tab();
    int n, w0, er, ec;
    @(negedge sys_clk);
    clrn = 1'b0;
    @(negedge sys_clk);
    clrn = 1'b1;
    m_row = 0;
    m_col = 0;
    send_char(7'h0A); wait_idle(n);
    send_char(7'h0A); wait_idle(n);
    for (int i = 0; i < 77; i++) begin
      send_char(7'($urandom_range(32, 126)));
      wait_idle(n);
    end
    w0 = wr_cnt;
    send_char(7'h09);
    wait_idle(n);
`ifdef VGA_CONSOLE_TAB_EN
    er = 3; ec = 0;
`else
    er = 2; ec = 77;
`endif
    n_checks++;
    if (wr_cnt != w0 || n != 0 || cur_row !== 6'(er) || cur_col !== 7'(ec)) begin
      n_errors++;
      $display("FAIL tab_wrap: writes=%0d busy=%0d (%0d,%0d) required 0 0 (%0d,%0d)", wr_cnt - w0, n, cur_row, cur_col, er, ec);
    end
    send_char(7'h0D);
    for (int i = 0; i < 3; i++) begin
      send_char(7'h2E);
      wait_idle(n);
    end
    send_char(7'h09);
    wait_idle(n);
    n_checks++;
    if (cur_row !== 6'(m_row) || cur_col !== 7'(m_col) || ram_diffs() != 0) begin
      n_errors++;
      $display("FAIL tab_mid: (%0d,%0d) diffs=%0d required (%0d,%0d) 0", cur_row, cur_col, ram_diffs(), m_row, m_col);
    end
  endtask

  task automatic test_random();
    int n;
    logic [6:0] c;
    for (int i = 0; i < 60; i++) begin
      c = rand_char();
      send_char(c);
      wait_idle(n);
      n_checks++;
      if (cur_row !== 6'(m_row) || cur_col !== 7'(m_col)) begin
        n_errors++;
        $display("FAIL random_cursor[%0d] code=%h: (%0d,%0d) required (%0d,%0d)", i, c, cur_row, cur_col, m_row, m_col);
      end
    end
    n_checks++;
    if (ram_diffs() != 0) begin
      n_errors++;
      $display("FAIL random_ram: %0d cells differ, required 0", ram_diffs());
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int i = 0; i < 120; i++) send_char(rand_char());
    wait_idle(n);
    n_checks++;
    if (cur_row !== 6'(m_row) || cur_col !== 7'(m_col)) begin
      n_errors++;
      $display("FAIL b2b_cursor: (%0d,%0d) required (%0d,%0d)", cur_row, cur_col, m_row, m_col);
    end
    n_checks++;
    if (ram_diffs() != 0) begin
      n_errors++;
      $display("FAIL b2b_ram: %0d cells differ, required 0", ram_diffs());
    end
  endtask

  initial begin
    test_reset();
    test_put_char();
    test_row_fill();
    test_scroll();
    test_clear();
    test_reset_mid_clear();
    test_backspace();
    test_tab();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
